// File: rtl/mem_port_arbiter_if.sv
// Fetch-side, data-side and memory-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory view.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_if_req;
  logic [WIDTH-1:0] i_if_addr;
  logic             o_if_gnt;
  logic             o_if_valid;
  logic [WIDTH-1:0] o_if_rdata;

  logic             i_dm_req;
  logic             i_dm_we;
  logic [WIDTH-1:0] i_dm_addr;
  logic [WIDTH-1:0] i_dm_wdata;
  logic             o_dm_gnt;
  logic             o_dm_valid;
  logic [WIDTH-1:0] o_dm_rdata;

  logic             o_mem_en;
  logic             o_mem_we;
  logic [WIDTH-1:0] o_mem_addr;
  logic [WIDTH-1:0] o_mem_wdata;
  logic [WIDTH-1:0] i_mem_rdata;

  logic             o_stall_F;
  logic             o_stall_MEM;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_valid, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    output o_dm_gnt, o_dm_valid, o_dm_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_stall_F, o_stall_MEM
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_valid, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    input  o_dm_gnt, o_dm_valid, o_dm_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_stall_F, o_stall_MEM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (IF) and data (DM) requests onto one fixed-latency single-ported memory.
// Optional macro ARB_STARVE_GUARD_EN bounds consecutive DM grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  // Register holds cycles remaining after the grant cycle, so completion lands at t+MEM_LAT.
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_lat_cnt;
  logic [CW-1:0]    w_lat_cnt_nxt;
  logic             r_dm_we;
  logic             w_dm_we_nxt;

  logic             w_arb;
  logic             w_starve_force;
  logic             w_if_gnt;
  logic             w_dm_gnt;
  logic             w_if_valid;
  logic             w_dm_valid;
  logic             w_mem_en;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= CNT_ZERO;
      r_dm_we   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_dm_we   <= w_dm_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_dm_we_nxt   = r_dm_we;
    w_arb         = 1'b0;
    w_if_valid    = 1'b0;
    w_dm_valid    = 1'b0;
    w_if_gnt      = 1'b0;
    w_dm_gnt      = 1'b0;
    w_mem_en      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = {WIDTH{1'b0}};
    w_mem_wdata   = {WIDTH{1'b0}};

    case (r_state)
      ST_IDLE: begin
        w_arb = 1'b1;
      end
      ST_BUSY_IF: begin
        if (r_lat_cnt == CNT_ZERO) begin
          w_if_valid  = bus.i_if_req;
          w_state_nxt = ST_IDLE;
          w_arb       = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - CNT_ONE;
        end
      end
      ST_BUSY_DM: begin
        if (r_lat_cnt == CNT_ZERO) begin
          w_dm_valid  = bus.i_dm_req;
          w_state_nxt = ST_IDLE;
          w_arb       = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Reset gates arbitration so nothing is issued while rst is high.
    if (w_arb && !i_rst) begin
      if (bus.i_dm_req && !(bus.i_if_req && w_starve_force)) begin
        w_dm_gnt      = 1'b1;
        w_mem_en      = 1'b1;
        w_mem_we      = bus.i_dm_we;
        w_mem_addr    = bus.i_dm_addr;
        w_mem_wdata   = bus.i_dm_wdata;
        w_dm_we_nxt   = bus.i_dm_we;
        w_state_nxt   = ST_BUSY_DM;
        w_lat_cnt_nxt = LAT_LOAD;
      end else if (bus.i_if_req) begin
        w_if_gnt      = 1'b1;
        w_mem_en      = 1'b1;
        w_mem_addr    = bus.i_if_addr;
        w_state_nxt   = ST_BUSY_IF;
        w_lat_cnt_nxt = LAT_LOAD;
      end else begin
        w_mem_en = 1'b0;
      end
    end else begin
      w_mem_en = 1'b0;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_ZERO = SW'(0);

  logic [SW-1:0] r_starve_cnt;

  // Counts DM grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= STARVE_ZERO;
    end else if (!bus.i_if_req || w_if_gnt) begin
      r_starve_cnt <= STARVE_ZERO;
    end else if (w_dm_gnt && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + STARVE_ONE;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  assign w_starve_force = (r_starve_cnt == STARVE_LIM);
`else
  assign w_starve_force = 1'b0;
`endif

  assign bus.o_if_gnt    = w_if_gnt;
  assign bus.o_dm_gnt    = w_dm_gnt;
  assign bus.o_if_valid  = w_if_valid;
  assign bus.o_dm_valid  = w_dm_valid;
  assign bus.o_if_rdata  = w_if_valid ? bus.i_mem_rdata : {WIDTH{1'b0}};
  // A completed store carries no read data.
  assign bus.o_dm_rdata  = (w_dm_valid && !r_dm_we) ? bus.i_mem_rdata : {WIDTH{1'b0}};
  assign bus.o_mem_en    = w_mem_en;
  assign bus.o_mem_we    = w_mem_we;
  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_wdata = w_mem_wdata;
  assign bus.o_stall_F   = bus.i_if_req & ~w_if_valid;
  assign bus.o_stall_MEM = bus.i_dm_req & ~w_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4) with a response scoreboard.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] r_pipe0;
  logic [31:0] r_pipe1;
  logic exp_dm;
  logic exp_if;

  mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mem_port_arbiter #(
    .WIDTH(WIDTH),
    .MEM_LAT(2),
    .STARVE_MAX(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Two-cycle memory: data for an access appears two cycles after mem_en.
  always @(posedge clk) begin
    r_pipe0 <= bus.o_mem_en ? mem_f(bus.o_mem_addr) : 32'hFFFF_FFFF;
    r_pipe1 <= r_pipe0;
  end
  assign bus.i_mem_rdata = r_pipe1;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.o_if_valid === 1'b1) begin
      if (if_q.size() == 0) chk1("sb_if_unexpected_valid", bus.o_if_valid, 1'b0);
      else chk32("sb_if_rdata", bus.o_if_rdata, if_q.pop_front());
    end
    if (bus.o_dm_valid === 1'b1) begin
      if (dm_q.size() == 0) chk1("sb_dm_unexpected_valid", bus.o_dm_valid, 1'b0);
      else chk32("sb_dm_rdata", bus.o_dm_rdata, dm_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    bus.i_if_req = 1'b0;  bus.i_if_addr = 32'h0;
    bus.i_dm_req = 1'b0;  bus.i_dm_we = 1'b0;
    bus.i_dm_addr = 32'h0; bus.i_dm_wdata = 32'h0;

    // Reset state
    #2;
    chk1 ("rst_if_gnt",   bus.o_if_gnt,    1'b0);
    chk1 ("rst_dm_gnt",   bus.o_dm_gnt,    1'b0);
    chk1 ("rst_if_valid", bus.o_if_valid,  1'b0);
    chk1 ("rst_dm_valid", bus.o_dm_valid,  1'b0);
    chk1 ("rst_mem_en",   bus.o_mem_en,    1'b0);
    chk1 ("rst_mem_we",   bus.o_mem_we,    1'b0);
    chk32("rst_mem_addr", bus.o_mem_addr,  32'h0);
    chk32("rst_mem_wdata",bus.o_mem_wdata, 32'h0);
    chk32("rst_if_rdata", bus.o_if_rdata,  32'h0);
    chk32("rst_dm_rdata", bus.o_dm_rdata,  32'h0);
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h70;
    #1;
    chk1("rst_req_no_gnt", bus.o_if_gnt, 1'b0);
    chk1("rst_req_no_en",  bus.o_mem_en, 1'b0);
    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // 1: fetch only
    tick(); bus.i_if_req = 1'b1; bus.i_if_addr = 32'h10; settle();
    chk1 ("t1_c0_if_gnt",   bus.o_if_gnt,   1'b1);
    chk1 ("t1_c0_mem_en",   bus.o_mem_en,   1'b1);
    chk32("t1_c0_mem_addr", bus.o_mem_addr, 32'h10);
    chk1 ("t1_c0_mem_we",   bus.o_mem_we,   1'b0);
    chk1 ("t1_c0_stall_F",  bus.o_stall_F,  1'b1);
    if_q.push_back(mem_f(32'h10));
    tick(); settle();
    chk1 ("t1_c1_if_gnt",   bus.o_if_gnt,   1'b0);
    chk1 ("t1_c1_mem_en",   bus.o_mem_en,   1'b0);
    chk32("t1_c1_mem_addr", bus.o_mem_addr, 32'h0);
    chk32("t1_c1_if_rdata", bus.o_if_rdata, 32'h0);
    tick(); settle();
    chk1 ("t1_c2_if_valid", bus.o_if_valid, 1'b1);
    chk32("t1_c2_if_rdata", bus.o_if_rdata, mem_f(32'h10));
    chk1 ("t1_c2_if_gnt",   bus.o_if_gnt,   1'b1);
    chk1 ("t1_c2_stall_F",  bus.o_stall_F,  1'b0);
    if_q.push_back(mem_f(32'h10));
    tick(); bus.i_if_req = 1'b0; void'(if_q.pop_back()); settle();
    chk1("t1_c3_mem_en", bus.o_mem_en, 1'b0);
    tick(); settle();
    chk1("t1_c4_if_valid", bus.o_if_valid, 1'b0);

    // 2: collision, data side first
    tick();
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h20;
    bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_addr = 32'h100;
    settle();
    chk1 ("t2_c0_dm_gnt",    bus.o_dm_gnt,    1'b1);
    chk1 ("t2_c0_if_gnt",    bus.o_if_gnt,    1'b0);
    chk32("t2_c0_mem_addr",  bus.o_mem_addr,  32'h100);
    chk1 ("t2_c0_stall_F",   bus.o_stall_F,   1'b1);
    chk1 ("t2_c0_stall_MEM", bus.o_stall_MEM, 1'b1);
    dm_q.push_back(mem_f(32'h100));
    tick(); settle();
    chk1("t2_c1_stall_F", bus.o_stall_F, 1'b1);
    chk1("t2_c1_mem_en",  bus.o_mem_en,  1'b0);
    tick(); settle();
    chk1 ("t2_c2_dm_valid",  bus.o_dm_valid,  1'b1);
    chk32("t2_c2_dm_rdata",  bus.o_dm_rdata,  mem_f(32'h100));
    chk1 ("t2_c2_dm_regnt",  bus.o_dm_gnt,    1'b1);
    chk1 ("t2_c2_if_gnt",    bus.o_if_gnt,    1'b0);
    chk1 ("t2_c2_stall_MEM", bus.o_stall_MEM, 1'b0);
    chk1 ("t2_c2_stall_F",   bus.o_stall_F,   1'b1);
    dm_q.push_back(mem_f(32'h100));
    tick(); bus.i_dm_req = 1'b0; void'(dm_q.pop_back()); settle();
    chk1("t2_c3_stall_F", bus.o_stall_F, 1'b1);
    tick(); settle();
    chk1 ("t2_c4_dm_valid", bus.o_dm_valid, 1'b0);
    chk1 ("t2_c4_if_gnt",   bus.o_if_gnt,   1'b1);
    chk32("t2_c4_mem_addr", bus.o_mem_addr, 32'h20);
    if_q.push_back(mem_f(32'h20));
    tick(); settle();
    chk1("t2_c5_stall_F", bus.o_stall_F, 1'b1);
    tick(); settle();
    chk1 ("t2_c6_if_valid", bus.o_if_valid, 1'b1);
    chk32("t2_c6_if_rdata", bus.o_if_rdata, mem_f(32'h20));
    if_q.push_back(mem_f(32'h20));
    tick(); bus.i_if_req = 1'b0; void'(if_q.pop_back()); settle();
    chk1("t2_c7_stall_F", bus.o_stall_F, 1'b0);
    tick(); settle();
    chk1("t2_c8_if_valid", bus.o_if_valid, 1'b0);

    // 3: store
    tick();
    bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b1;
    bus.i_dm_addr = 32'h100; bus.i_dm_wdata = 32'hDEADBEEF;
    settle();
    chk1 ("t3_c0_dm_gnt",    bus.o_dm_gnt,    1'b1);
    chk1 ("t3_c0_mem_en",    bus.o_mem_en,    1'b1);
    chk1 ("t3_c0_mem_we",    bus.o_mem_we,    1'b1);
    chk32("t3_c0_mem_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
    chk32("t3_c0_mem_addr",  bus.o_mem_addr,  32'h100);
    dm_q.push_back(32'h0);
    tick(); settle();
    chk1 ("t3_c1_mem_en",    bus.o_mem_en,    1'b0);
    chk1 ("t3_c1_mem_we",    bus.o_mem_we,    1'b0);
    chk32("t3_c1_mem_wdata", bus.o_mem_wdata, 32'h0);
    tick(); settle();
    chk1 ("t3_c2_dm_valid", bus.o_dm_valid, 1'b1);
    chk32("t3_c2_dm_rdata", bus.o_dm_rdata, 32'h0);
    dm_q.push_back(32'h0);
    tick();
    bus.i_dm_req = 1'b0; bus.i_dm_we = 1'b0; bus.i_dm_wdata = 32'h0; bus.i_dm_addr = 32'h0;
    void'(dm_q.pop_back());
    settle();
    chk1("t3_c3_mem_en",    bus.o_mem_en,    1'b0);
    chk1("t3_c3_stall_MEM", bus.o_stall_MEM, 1'b0);
    tick(); settle();
    chk1("t3_c4_dm_valid", bus.o_dm_valid, 1'b0);

    // 4: flush
    tick(); bus.i_if_req = 1'b1; bus.i_if_addr = 32'h40; settle();
    chk1("t4_c0_if_gnt", bus.o_if_gnt, 1'b1);
    tick(); bus.i_if_req = 1'b0; settle();
    chk1("t4_c1_stall_F", bus.o_stall_F, 1'b0);
    tick(); settle();
    chk1("t4_c2_if_valid", bus.o_if_valid, 1'b0);
    chk1("t4_c2_mem_en",   bus.o_mem_en,   1'b0);
    tick(); bus.i_if_req = 1'b1; bus.i_if_addr = 32'h44; settle();
    chk1 ("t4_c3_if_gnt",   bus.o_if_gnt,   1'b1);
    chk32("t4_c3_mem_addr", bus.o_mem_addr, 32'h44);
    if_q.push_back(mem_f(32'h44));
    tick(); tick(); settle();
    chk1 ("t4_c5_if_valid", bus.o_if_valid, 1'b1);
    chk32("t4_c5_if_rdata", bus.o_if_rdata, mem_f(32'h44));
    if_q.push_back(mem_f(32'h44));
    tick(); bus.i_if_req = 1'b0; void'(if_q.pop_back());
    tick(); settle();
    chk1("t4_c7_if_valid", bus.o_if_valid, 1'b0);

    // 5: reset mid-transaction
    tick(); bus.i_if_req = 1'b1; bus.i_if_addr = 32'h50; settle();
    chk1("t5_c0_if_gnt", bus.o_if_gnt, 1'b1);
    tick(); rst = 1'b1; #1;
    chk1 ("t5_rst_if_gnt",    bus.o_if_gnt,    1'b0);
    chk1 ("t5_rst_if_valid",  bus.o_if_valid,  1'b0);
    chk1 ("t5_rst_mem_en",    bus.o_mem_en,    1'b0);
    chk32("t5_rst_mem_addr",  bus.o_mem_addr,  32'h0);
    chk32("t5_rst_if_rdata",  bus.o_if_rdata,  32'h0);
    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0;
    tick(); tick(); rst = 1'b0; settle();
    chk1("t5_c3_if_valid", bus.o_if_valid, 1'b0);
    chk1("t5_c3_mem_en",   bus.o_mem_en,   1'b0);
    tick(); settle();
    chk1("t5_c4_if_valid", bus.o_if_valid, 1'b0);

    // 6: starvation
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_addr = 32'h200;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h60;
      end
      settle();
`ifdef ARB_STARVE_GUARD_EN
      exp_dm = ((k % 2) == 0) && (k < 8);
      exp_if = (k == 8);
`else
      exp_dm = ((k % 2) == 0);
      exp_if = 1'b0;
`endif
      chk1($sformatf("t6_k%0d_dm_gnt", k), bus.o_dm_gnt, exp_dm);
      chk1($sformatf("t6_k%0d_if_gnt", k), bus.o_if_gnt, exp_if);
      if (exp_dm) dm_q.push_back(mem_f(32'h200));
      if (exp_if) if_q.push_back(mem_f(32'h60));
    end
    tick();
    bus.i_dm_req = 1'b0; bus.i_if_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    void'(if_q.pop_back());
`else
    void'(dm_q.pop_back());
`endif
    settle();
    chk1("t6_end_stall_F",   bus.o_stall_F,   1'b0);
    chk1("t6_end_stall_MEM", bus.o_stall_MEM, 1'b0);
    tick(); settle();
    chk1("t6_end_if_valid", bus.o_if_valid, 1'b0);
    chk1("t6_end_dm_valid", bus.o_dm_valid, 1'b0);
    tick(); tick();

    chk32("sb_if_drained", 32'(if_q.size()), 32'h0);
    chk32("sb_dm_drained", 32'(dm_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
